ysyx_23060184_mem_stage: RTL and testbench

Memory-access stage of the ysyx_23060184 five-stage core. It consumes the EX/MEM register outputs, runs one load/store transaction per instruction on a simple valid/ready data bus, and aligns store data and strobes. It sign- or zero-extends load data and holds the result for write-back. Toward EX it drives Mready; toward WB it presents a registered Wvalid/Wready slot.

---
 rtl/ysyx_23060184_mem_stage_pkg.sv | 30 +++
 rtl/ysyx_23060184_mem_stage_load_ext.sv | 35 +++
 rtl/ysyx_23060184_mem_stage.sv | 185 ++++++++++++++++++
 tb/tb_ysyx_23060184_mem_stage.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060184_mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_defs (package)
// Purpose  : Shared widths, load-type encodings and memory-stage FSM states
//            for the ysyx_23060184 MEM stage.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060184_defs;

    localparam int DATA_WIDTH        = 32;
    localparam int WMASK_LENGTH      = DATA_WIDTH / 8;
    localparam int ROPCODE_LENGTH    = 3;
    localparam int RESULT_SRC_LENGTH = 2;
    localparam int REG_LENGTH        = 5;

    // Load-extension opcodes; codes 5..7 fall back to a full-word load
    localparam logic [ROPCODE_LENGTH-1:0] ROP_LW  = 3'd0;
    localparam logic [ROPCODE_LENGTH-1:0] ROP_LB  = 3'd1;
    localparam logic [ROPCODE_LENGTH-1:0] ROP_LBU = 3'd2;
    localparam logic [ROPCODE_LENGTH-1:0] ROP_LH  = 3'd3;
    localparam logic [ROPCODE_LENGTH-1:0] ROP_LHU = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } memState_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060184_mem_stage_load_ext.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_load_ext
// Purpose  : Shifts the addressed lane of a bus word down to bit 0 and
//            sign- or zero-extends it according to the load type.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060184_load_ext
    import ysyx_23060184_defs::*;
(
    input  logic [DATA_WIDTH-1:0]     i_rdata,
    input  logic [1:0]                i_off,
    input  logic [ROPCODE_LENGTH-1:0] i_ropcode,
    output logic [DATA_WIDTH-1:0]     o_loadValue
);

    logic [DATA_WIDTH-1:0] w_shifted;

    // Bytes above the word end shift in as zero; misaligned halves are not split
    assign w_shifted = i_rdata >> {i_off, 3'b000};

    // Select the lane slice and widen it per load type
    always_comb begin
        o_loadValue = w_shifted;
        case (i_ropcode)
            ROP_LB:  o_loadValue = {{(DATA_WIDTH-8){w_shifted[7]}}, w_shifted[7:0]};
            ROP_LBU: o_loadValue = {{(DATA_WIDTH-8){1'b0}}, w_shifted[7:0]};
            ROP_LH:  o_loadValue = {{(DATA_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
            ROP_LHU: o_loadValue = {{(DATA_WIDTH-16){1'b0}}, w_shifted[15:0]};
            default: o_loadValue = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060184_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060184_mem_stage
// Purpose  : Memory-access stage. Runs one valid/ready bus transaction per
//            load/store, aligns store data and strobes, extends load data
//            and holds the result in a registered write-back slot.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060184_mem_stage
    import ysyx_23060184_defs::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         Mvalid,
    output logic                         Mready,
    input  logic                         RegWriteM,
    input  logic                         MemReadM,
    input  logic                         MemWriteM,
    input  logic [WMASK_LENGTH-1:0]      WmaskM,
    input  logic [ROPCODE_LENGTH-1:0]    RopcodeM,
    input  logic [RESULT_SRC_LENGTH-1:0] ResultSrcM,
    input  logic [DATA_WIDTH-1:0]        WriteDataM,
    input  logic [DATA_WIDTH-1:0]        PCPlus4M,
    input  logic [DATA_WIDTH-1:0]        CsrReadM,
    input  logic [DATA_WIDTH-1:0]        ALUResultM,
    input  logic [REG_LENGTH-1:0]        RdM,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic                         req_write,
    output logic [DATA_WIDTH-1:0]        req_addr,
    output logic [DATA_WIDTH-1:0]        req_wdata,
    output logic [WMASK_LENGTH-1:0]      req_wstrb,
    input  logic                         resp_valid,
    input  logic [DATA_WIDTH-1:0]        resp_rdata,
    output logic                         Wvalid,
    input  logic                         Wready,
    output logic                         RegWriteW,
    output logic [RESULT_SRC_LENGTH-1:0] ResultSrcW,
    output logic [REG_LENGTH-1:0]        RdW,
    output logic [DATA_WIDTH-1:0]        PCPlus4W,
    output logic [DATA_WIDTH-1:0]        CsrReadW,
    output logic [DATA_WIDTH-1:0]        ALUResultW,
    output logic [DATA_WIDTH-1:0]        ReadDataW
);

    memState_t                    r_state;

    // Captured instruction, held stable while the bus transaction runs
    logic                         r_regWrite;
    logic                         r_memRead;
    logic                         r_memWrite;
    logic [WMASK_LENGTH-1:0]      r_wmask;
    logic [ROPCODE_LENGTH-1:0]    r_ropcode;
    logic [RESULT_SRC_LENGTH-1:0] r_resultSrc;
    logic [DATA_WIDTH-1:0]        r_writeData;
    logic [DATA_WIDTH-1:0]        r_pcPlus4;
    logic [DATA_WIDTH-1:0]        r_csrRead;
    logic [DATA_WIDTH-1:0]        r_aluResult;
    logic [REG_LENGTH-1:0]        r_rd;

    // Write-back slot
    logic                         r_wValid;
    logic                         r_regWriteW;
    logic [RESULT_SRC_LENGTH-1:0] r_resultSrcW;
    logic [REG_LENGTH-1:0]        r_rdW;
    logic [DATA_WIDTH-1:0]        r_pcPlus4W;
    logic [DATA_WIDTH-1:0]        r_csrReadW;
    logic [DATA_WIDTH-1:0]        r_aluResultW;
    logic [DATA_WIDTH-1:0]        r_readDataW;

    logic                         w_accept;
    logic                         w_isMem;
    logic [1:0]                   w_off;
    logic [DATA_WIDTH-1:0]        w_loadValue;

    // New work only when idle and the slot is free or draining this edge
    assign Mready   = (r_state == ST_IDLE) && (!r_wValid || Wready);
    assign w_accept = Mvalid && Mready;
    assign w_isMem  = MemReadM || MemWriteM;
    assign w_off    = r_aluResult[1:0];

    // Bus request: address word-aligned, store lanes shifted into place
    assign req_valid = (r_state == ST_REQ);
    assign req_write = r_memWrite;
    assign req_addr  = {r_aluResult[DATA_WIDTH-1:2], 2'b00};
    assign req_wdata = r_writeData << {w_off, 3'b000};
    assign req_wstrb = r_memWrite ? (r_wmask << w_off) : '0;

    assign Wvalid     = r_wValid;
    assign RegWriteW  = r_regWriteW;
    assign ResultSrcW = r_resultSrcW;
    assign RdW        = r_rdW;
    assign PCPlus4W   = r_pcPlus4W;
    assign CsrReadW   = r_csrReadW;
    assign ALUResultW = r_aluResultW;
    assign ReadDataW  = r_readDataW;

    ysyx_23060184_load_ext u_loadExt (
        .i_rdata     (resp_rdata),
        .i_off       (w_off),
        .i_ropcode   (r_ropcode),
        .o_loadValue (w_loadValue)
    );

    // Stage FSM: accept, issue request, await response, fill write-back slot
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_regWrite   <= 1'b0;
            r_memRead    <= 1'b0;
            r_memWrite   <= 1'b0;
            r_wmask      <= '0;
            r_ropcode    <= '0;
            r_resultSrc  <= '0;
            r_writeData  <= '0;
            r_pcPlus4    <= '0;
            r_csrRead    <= '0;
            r_aluResult  <= '0;
            r_rd         <= '0;
            r_wValid     <= 1'b0;
            r_regWriteW  <= 1'b0;
            r_resultSrcW <= '0;
            r_rdW        <= '0;
            r_pcPlus4W   <= '0;
            r_csrReadW   <= '0;
            r_aluResultW <= '0;
            r_readDataW  <= '0;
        end else begin
            // Slot drains on Wready; a result loaded below on this edge wins
            if (r_wValid && Wready) begin
                r_wValid <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_regWrite  <= RegWriteM;
                        r_memRead   <= MemReadM;
                        r_memWrite  <= MemWriteM;
                        r_wmask     <= WmaskM;
                        r_ropcode   <= RopcodeM;
                        r_resultSrc <= ResultSrcM;
                        r_writeData <= WriteDataM;
                        r_pcPlus4   <= PCPlus4M;
                        r_csrRead   <= CsrReadM;
                        r_aluResult <= ALUResultM;
                        r_rd        <= RdM;
                        if (w_isMem) begin
                            r_state <= ST_REQ;
                        end else begin
                            r_wValid     <= 1'b1;
                            r_regWriteW  <= RegWriteM;
                            r_resultSrcW <= ResultSrcM;
                            r_rdW        <= RdM;
                            r_pcPlus4W   <= PCPlus4M;
                            r_csrReadW   <= CsrReadM;
                            r_aluResultW <= ALUResultM;
                            r_readDataW  <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (req_ready) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_valid) begin
                        r_state      <= ST_IDLE;
                        r_wValid     <= 1'b1;
                        r_regWriteW  <= r_regWrite;
                        r_resultSrcW <= r_resultSrc;
                        r_rdW        <= r_rd;
                        r_pcPlus4W   <= r_pcPlus4;
                        r_csrReadW   <= r_csrRead;
                        r_aluResultW <= r_aluResult;
                        r_readDataW  <= r_memRead ? w_loadValue : '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060184_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_23060184_mem_stage
// Purpose  : Self-checking bench for the MEM stage: directed scenarios plus
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060184_mem_stage;

    logic        clk;
    logic        reset;
    logic        Mvalid, Mready;
    logic        RegWriteM, MemReadM, MemWriteM;
    logic [3:0]  WmaskM;
    logic [2:0]  RopcodeM;
    logic [1:0]  ResultSrcM;
    logic [31:0] WriteDataM, PCPlus4M, CsrReadM, ALUResultM;
    logic [4:0]  RdM;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        Wvalid, Wready, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RdW;
    logic [31:0] PCPlus4W, CsrReadW, ALUResultW, ReadDataW;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ysyx_23060184_mem_stage dut (
        .clk        (clk),
        .reset      (reset),
        .Mvalid     (Mvalid),
        .Mready     (Mready),
        .RegWriteM  (RegWriteM),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .WmaskM     (WmaskM),
        .RopcodeM   (RopcodeM),
        .ResultSrcM (ResultSrcM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M),
        .CsrReadM   (CsrReadM),
        .ALUResultM (ALUResultM),
        .RdM        (RdM),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .Wvalid     (Wvalid),
        .Wready     (Wready),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .RdW        (RdW),
        .PCPlus4W   (PCPlus4W),
        .CsrReadW   (CsrReadW),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW)
    );

    typedef struct {
        logic        regWrite, memRead, memWrite;
        logic [3:0]  wmask;
        logic [2:0]  rop;
        logic [1:0]  resultSrc;
        logic [31:0] writeData, pcPlus4, csrRead, alu;
        logic [4:0]  rd;
    } instr_t;

    typedef struct {
        logic        regWrite;
        logic [1:0]  resultSrc;
        logic [4:0]  rd;
        logic [31:0] pcPlus4, csrRead, alu, readData;
    } wb_t;

    // Reference model: one instruction in flight, one write-back slot
    bit     mPend, mWait, mFull;
    instr_t mCur;
    wb_t    mWb;
    int     nVec, nBad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] expStoreData(logic [31:0] data, logic [1:0] off);
        longint unsigned prod;
        prod = longint'(data) * (64'd1 << (8 * int'(off)));
        return 32'(prod);
    endfunction

    function automatic logic [3:0] expStrobe(logic [3:0] mask, logic [1:0] off);
        int m;
        m = int'(mask) * (1 << int'(off));
        return 4'(m);
    endfunction

    // Gather the addressed bytes little-endian, drop those past the word end
    function automatic logic [31:0] expLoad(logic [31:0] word, logic [1:0] off, logic [2:0] rop);
        int unsigned     lane [4];
        int              nBytes, o;
        longint unsigned v;
        for (int i = 0; i < 4; i++) lane[i] = (word >> (8 * i)) & 32'hFF;
        nBytes = (rop == 3'd1 || rop == 3'd2) ? 1 : (rop == 3'd3 || rop == 3'd4) ? 2 : 4;
        o = int'(off);
        v = 0;
        for (int k = 0; k < nBytes; k++)
            if (o + k < 4) v += longint'(lane[o + k]) << (8 * k);
        if (rop == 3'd1 && v >= 128)   v = v + 64'h1_0000_0000 - 256;
        if (rop == 3'd3 && v >= 32768) v = v + 64'h1_0000_0000 - 65536;
        return 32'(v);
    endfunction

    function automatic wb_t wbOf(instr_t ins, logic [31:0] rdata);
        wb_t w;
        w.regWrite  = ins.regWrite;
        w.resultSrc = ins.resultSrc;
        w.rd        = ins.rd;
        w.pcPlus4   = ins.pcPlus4;
        w.csrRead   = ins.csrRead;
        w.alu       = ins.alu;
        w.readData  = rdata;
        return w;
    endfunction

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [3:0] mask, input logic [2:0] rop,
                         input logic [4:0] rdIdx);
        Mvalid     = v;
        MemReadM   = rd;
        MemWriteM  = wr;
        ALUResultM = alu;
        WriteDataM = wd;
        WmaskM     = mask;
        RopcodeM   = rop;
        RdM        = rdIdx;
        RegWriteM  = 1'($urandom_range(0, 1));
        ResultSrcM = 2'($urandom_range(0, 3));
        PCPlus4M   = $urandom;
        CsrReadM   = $urandom;
    endtask

    // Called at a falling edge with inputs set: check outputs, advance model one clock
    task automatic step();
        logic   expMready;
        instr_t ins;
        #1;
        expMready = !(mPend || mWait) && (!mFull || Wready);
        chk("Mready", 32'(Mready), 32'(expMready));
        chk("req_valid", 32'(req_valid), 32'(mPend));
        if (mPend) begin
            chk("req_addr", req_addr, mCur.alu & 32'hFFFF_FFFC);
            chk("req_write", 32'(req_write), 32'(mCur.memWrite));
            chk("req_wdata", req_wdata, expStoreData(mCur.writeData, mCur.alu[1:0]));
            chk("req_wstrb", 32'(req_wstrb),
                mCur.memWrite ? 32'(expStrobe(mCur.wmask, mCur.alu[1:0])) : 32'h0);
        end
        chk("Wvalid", 32'(Wvalid), 32'(mFull));
        if (mFull) begin
            chk("RegWriteW", 32'(RegWriteW), 32'(mWb.regWrite));
            chk("ResultSrcW", 32'(ResultSrcW), 32'(mWb.resultSrc));
            chk("RdW", 32'(RdW), 32'(mWb.rd));
            chk("PCPlus4W", PCPlus4W, mWb.pcPlus4);
            chk("CsrReadW", CsrReadW, mWb.csrRead);
            chk("ALUResultW", ALUResultW, mWb.alu);
            chk("ReadDataW", ReadDataW, mWb.readData);
        end
        if (reset) begin
            mPend = 0; mWait = 0; mFull = 0;
        end else begin
            if (mFull && Wready) mFull = 0;
            if (mWait && resp_valid) begin
                mWait = 0;
                mFull = 1;
                mWb   = wbOf(mCur, mCur.memRead ? expLoad(resp_rdata, mCur.alu[1:0], mCur.rop) : 32'h0);
            end else if (mPend && req_ready) begin
                mPend = 0;
                mWait = 1;
            end
            if (Mvalid && expMready) begin
                ins.regWrite = RegWriteM;  ins.memRead = MemReadM;   ins.memWrite = MemWriteM;
                ins.wmask = WmaskM;        ins.rop = RopcodeM;       ins.resultSrc = ResultSrcM;
                ins.writeData = WriteDataM; ins.pcPlus4 = PCPlus4M;  ins.csrRead = CsrReadM;
                ins.alu = ALUResultM;      ins.rd = RdM;
                mCur = ins;
                if (MemReadM || MemWriteM) mPend = 1;
                else begin
                    mFull = 1;
                    mWb   = wbOf(ins, 32'h0);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic loadCase(input logic [2:0] rop, input logic [31:0] expv);
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h0, 4'h0, rop, 5'd9);
        req_ready = 1'b1; resp_valid = 1'b1; resp_rdata = 32'h80F0_1234;
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0, 5'd0);
        chk("ld_req_valid", 32'(req_valid), 32'h1);
        step();
        chk("ld_early_Wvalid", 32'(Wvalid), 32'h0);
        step();
        chk("ld_Wvalid", 32'(Wvalid), 32'h1);
        chk("ld_value", ReadDataW, expv);
        req_ready = 1'b0; resp_valid = 1'b0;
    endtask

    int kind;

    initial begin
        nVec = 0; nBad = 0; mPend = 0; mWait = 0; mFull = 0;
        reset = 1'b1; Wready = 1'b1; req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 32'h0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0, 5'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        #1;
        chk("rst_Wvalid", 32'(Wvalid), 32'h0);
        chk("rst_req_valid", 32'(req_valid), 32'h0);
        chk("rst_Mready", 32'(Mready), 32'h1);
        chk("rst_RegWriteW", 32'(RegWriteW), 32'h0);
        chk("rst_RdW", 32'(RdW), 32'h0);
        chk("rst_ALUResultW", ALUResultW, 32'h0);
        chk("rst_PCPlus4W", PCPlus4W, 32'h0);
        chk("rst_ReadDataW", ReadDataW, 32'h0);
        step();

        // ADD-type passthrough, one cycle latency
        drive(1'b1, 1'b0, 1'b0, 32'h0000_1234, 32'h0, 4'hF, 3'd0, 5'd5);
        RegWriteM = 1'b1;
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0, 5'd0);
        chk("add_Wvalid", 32'(Wvalid), 32'h1);
        chk("add_alu", ALUResultW, 32'h0000_1234);
        chk("add_rd", 32'(RdW), 32'd5);
        chk("add_regwrite", 32'(RegWriteW), 32'h1);
        chk("add_rdata", ReadDataW, 32'h0);
        step();

        // SB to byte 3
        drive(1'b1, 1'b0, 1'b1, 32'h8000_0003, 32'h0000_00AB, 4'h1, 3'd0, 5'd3);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0, 5'd0);
        chk("sb_req_valid", 32'(req_valid), 32'h1);
        chk("sb_addr", req_addr, 32'h8000_0000);
        chk("sb_wdata", req_wdata, 32'hAB00_0000);
        chk("sb_wstrb", 32'(req_wstrb), 32'h8);
        chk("sb_write", 32'(req_write), 32'h1);
        step();
        req_ready = 1'b1; step();
        req_ready = 1'b0; resp_valid = 1'b1; resp_rdata = $urandom; step();
        resp_valid = 1'b0;
        chk("sb_Wvalid", 32'(Wvalid), 32'h1);
        chk("sb_rdata", ReadDataW, 32'h0);

        // Sub-word loads at offset 2, Wvalid exactly three cycles after accept
        loadCase(3'd1, 32'hFFFF_FFF0);
        loadCase(3'd4, 32'h0000_80F0);

        // Write-back backpressure, then accept on the draining edge
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0000_AAAA, 32'h0, 4'h0, 3'd0, 5'd1);
        Wready = 1'b0;
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0000_5555, 32'h0, 4'h0, 3'd0, 5'd2);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_Mready", 32'(Mready), 32'h0);
            chk("bp_Wvalid", 32'(Wvalid), 32'h1);
            chk("bp_alu", ALUResultW, 32'h0000_AAAA);
            step();
        end
        Wready = 1'b1;
        step();
        chk("bp_next_alu", ALUResultW, 32'h0000_5555);
        chk("bp_next_Wvalid", 32'(Wvalid), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0, 5'd0);
        step();

        // Delayed req_ready with spurious responses while requesting
        drive(1'b1, 1'b0, 1'b1, 32'h0000_2001, 32'h1234_5678, 4'h3, 3'd0, 5'd4);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0, 5'd0);
        resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("dly_req_valid", 32'(req_valid), 32'h1);
            chk("dly_addr", req_addr, 32'h0000_2000);
            chk("dly_wdata", req_wdata, 32'h3456_7800);
            chk("dly_wstrb", 32'(req_wstrb), 32'h6);
            step();
        end
        resp_valid = 1'b0; req_ready = 1'b1; step();
        req_ready = 1'b0;
        chk("dly_resp_wait", 32'(Wvalid), 32'h0);
        resp_valid = 1'b1; step();
        resp_valid = 1'b0;
        chk("dly_done", 32'(Wvalid), 32'h1);
        step();

        // Reset while awaiting the response
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'd0, 5'd6);
        req_ready = 1'b1; step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'd0, 5'd0);
        step();
        req_ready = 1'b0; reset = 1'b1; step();
        reset = 1'b0;
        #1;
        chk("rr_req_valid", 32'(req_valid), 32'h0);
        chk("rr_Wvalid", 32'(Wvalid), 32'h0);
        chk("rr_Mready", 32'(Mready), 32'h1);
        resp_valid = 1'b1; resp_rdata = $urandom;
        step(); step();
        resp_valid = 1'b0;
        chk("rr_late_Wvalid", 32'(Wvalid), 32'h0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            kind = $urandom_range(0, 2);
            drive(1'($urandom_range(0, 9) < 7), kind == 1, kind == 2, $urandom, $urandom,
                  ($urandom_range(0, 2) == 0) ? 4'h1 : ($urandom_range(0, 1) == 0) ? 4'h3 : 4'hF,
                  3'($urandom_range(0, 7)), 5'($urandom));
            Wready     = 1'($urandom_range(0, 3) != 0);
            req_ready  = 1'($urandom_range(0, 1));
            resp_valid = 1'($urandom_range(0, 1));
            resp_rdata = $urandom;
            reset      = 1'($urandom_range(0, 299) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule
`default_nettype wire
